// File: rtl/fismos_mailbox_pkg.sv
// Shared definitions for the host/softcore mailbox: register map, AXI
// response codes, address-decode result and small decode helpers.
package fismos_mailbox_pkg;

  localparam logic [3:0] H2S_PEND = 4'h0;
  localparam logic [3:0] S2H_PEND = 4'h4;
  localparam logic [3:0] H2S_EN   = 4'h8;
  localparam logic [3:0] S2H_EN   = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_REG,
    REGION_ERR
  } region_e;

  function automatic region_e decode_word(input logic [31:0] word, input int unsigned mem_words);
    if (word < mem_words)            return REGION_RAM;
    else if (word < mem_words + 4)   return REGION_REG;
    else                             return REGION_ERR;
  endfunction

  // Byte offset of a register word relative to REG_BASE.
  function automatic logic [3:0] reg_offset(input logic [31:0] word, input int unsigned mem_words);
    logic [31:0] d;
    d = word - mem_words;
    return {d[1:0], 2'b00};
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (strb[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

endpackage

// File: rtl/fismos_mailbox_if.sv
// Bus bundle for the mailbox: host AXI4-Lite slave channels plus the
// native PicoRV32 memory interface.
interface fismos_mailbox_if #(
  parameter int unsigned ADDR_WIDTH = 13
);
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]            S_AXI_AWPROT;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]            S_AXI_ARPROT;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;

  logic                  mem_valid;
  logic                  mem_instr;
  logic                  mem_ready;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_rdata;

  modport master (
    output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_BREADY,
    output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
    input  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_BREADY,
    input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
    output S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/fismos_mailbox_ram.sv
// True dual-port byte-enabled word RAM with registered, read-enabled outputs.
// On a same-word, same-lane write collision port A wins.
module fismos_mailbox_ram #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          en_a,
  input  logic [3:0]    we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [31:0]   wdata_a,
  output logic [31:0]   q_a,
  input  logic          en_b,
  input  logic [3:0]    we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [31:0]   wdata_b,
  output logic [31:0]   q_b
);

  logic [31:0] mem [MEM_WORDS];

  // Port A is written last so its lanes take priority.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we_b[i]) mem[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
      if (we_a[i]) mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (en_a) q_a <= mem[addr_a];
      if (en_b) q_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/fismos_mailbox_dp.sv
// Host/softcore mailbox: AXI4-Lite host port, native PicoRV32 port, shared
// RAM and per-direction doorbell pending/enable registers with level IRQs.
module fismos_mailbox_dp
  import fismos_mailbox_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned NUM_CHANNELS = 4
)(
  input  logic             clk,
  input  logic             reset,
  output logic             interrupt_to_softcore,
  output logic             interrupt_to_linux,
  fismos_mailbox_if.slave  bus
);

  localparam int unsigned RAM_AW    = $clog2(MEM_WORDS);
  localparam logic [31:0] CHAN_MASK = 32'((64'd1 << NUM_CHANNELS) - 64'd1);

  function automatic logic [31:0] reg_mux(input logic [3:0] off, input logic [31:0] hp,
                                          input logic [31:0] sp, input logic [31:0] he,
                                          input logic [31:0] se);
    case (off)
      H2S_PEND: return hp;
      S2H_PEND: return sp;
      H2S_EN:   return he;
      default:  return se;
    endcase
  endfunction

  logic [31:0] h2s_pend, s2h_pend, h2s_en, s2h_en;

  // Address decode for the three request sources
  logic [31:0] aw_word, ar_word, pb_word;
  region_e     aw_region, ar_region, pb_region;
  logic [3:0]  aw_off, ar_off, pb_off;

  assign aw_word   = 32'(bus.S_AXI_AWADDR[ADDR_WIDTH-1:2]);
  assign ar_word   = 32'(bus.S_AXI_ARADDR[ADDR_WIDTH-1:2]);
  assign pb_word   = 32'(bus.mem_addr[ADDR_WIDTH-1:2]);
  assign aw_region = decode_word(aw_word, MEM_WORDS);
  assign ar_region = decode_word(ar_word, MEM_WORDS);
  assign pb_region = (|bus.mem_addr[31:ADDR_WIDTH]) ? REGION_ERR : decode_word(pb_word, MEM_WORDS);
  assign aw_off    = reg_offset(aw_word, MEM_WORDS);
  assign ar_off    = reg_offset(ar_word, MEM_WORDS);
  assign pb_off    = reg_offset(pb_word, MEM_WORDS);

  // Host write channel
  logic       awready_q, bvalid_q;
  logic [1:0] bresp_q;
  logic       aw_go, wr_fire, wr_err;

  assign aw_go   = bus.S_AXI_AWVALID && bus.S_AXI_WVALID && !bvalid_q && !awready_q && !reset;
  assign wr_fire = awready_q && bus.S_AXI_AWVALID && bus.S_AXI_WVALID && !reset;
  assign wr_err  = (aw_region == REGION_ERR) || (aw_region == REGION_REG && aw_off == H2S_EN);

  always_ff @(posedge clk) begin
    if (reset) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= aw_go;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && bus.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
        bresp_q  <= RESP_OKAY;
      end
    end
  end

  // Host read channel; held off for a cycle when a write is about to take RAM port A
  logic        arready_q, rvalid_q, rd_ram_q;
  logic [1:0]  rresp_q;
  logic [31:0] rd_reg_q;
  logic        ar_go, rd_fire;

  assign ar_go   = bus.S_AXI_ARVALID && !rvalid_q && !arready_q && !aw_go && !reset;
  assign rd_fire = arready_q && bus.S_AXI_ARVALID && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rd_ram_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rd_reg_q  <= '0;
    end else begin
      arready_q <= ar_go;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rresp_q  <= (ar_region == REGION_ERR) ? RESP_SLVERR : RESP_OKAY;
        rd_ram_q <= (ar_region == REGION_RAM);
        rd_reg_q <= (ar_region == REGION_REG) ?
                    reg_mux(ar_off, h2s_pend, s2h_pend, h2s_en, s2h_en) : '0;
      end else if (rvalid_q && bus.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Softcore port
  logic        mem_ready_q, pb_ram_q, pb_go, pb_wr;
  logic [31:0] pb_reg_q;

  assign pb_go = bus.mem_valid && !mem_ready_q && !reset;
  assign pb_wr = |bus.mem_wstrb;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready_q <= 1'b0;
      pb_ram_q    <= 1'b0;
      pb_reg_q    <= '0;
    end else begin
      mem_ready_q <= pb_go;
      pb_ram_q    <= pb_go && !pb_wr && (pb_region == REGION_RAM);
      pb_reg_q    <= (pb_go && !pb_wr && pb_region == REGION_REG) ?
                     reg_mux(pb_off, h2s_pend, s2h_pend, h2s_en, s2h_en) : '0;
    end
  end

  // Shared RAM
  logic [RAM_AW-1:0] ram_addr_a;
  logic [3:0]        ram_we_a, ram_we_b;
  logic              ram_en_a, ram_en_b;
  logic [31:0]       ram_q_a, ram_q_b;

  assign ram_addr_a = wr_fire ? aw_word[RAM_AW-1:0] : ar_word[RAM_AW-1:0];
  assign ram_we_a   = (wr_fire && aw_region == REGION_RAM) ? bus.S_AXI_WSTRB : '0;
  assign ram_en_a   = rd_fire && (ar_region == REGION_RAM);
  assign ram_we_b   = (pb_go && pb_region == REGION_RAM) ? bus.mem_wstrb : '0;
  assign ram_en_b   = pb_go && !pb_wr && (pb_region == REGION_RAM);

  fismos_mailbox_ram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .en_a    (ram_en_a),
    .we_a    (ram_we_a),
    .addr_a  (ram_addr_a),
    .wdata_a (bus.S_AXI_WDATA),
    .q_a     (ram_q_a),
    .en_b    (ram_en_b),
    .we_b    (ram_we_b),
    .addr_b  (pb_word[RAM_AW-1:0]),
    .wdata_b (bus.mem_wdata),
    .q_b     (ram_q_b)
  );

  // Doorbell registers
  logic        host_reg_wr, pico_reg_wr;
  logic [31:0] host_lanes, host_bits, pico_lanes, pico_bits;
  logic [31:0] h2s_set, h2s_clr, s2h_set, s2h_clr;

  assign host_reg_wr = wr_fire && (aw_region == REGION_REG);
  assign pico_reg_wr = pb_go && pb_wr && (pb_region == REGION_REG);
  assign host_lanes  = lane_mask(bus.S_AXI_WSTRB) & CHAN_MASK;
  assign host_bits   = bus.S_AXI_WDATA & host_lanes;
  assign pico_lanes  = lane_mask(bus.mem_wstrb) & CHAN_MASK;
  assign pico_bits   = bus.mem_wdata & pico_lanes;

  always_comb begin
    h2s_set = '0;
    h2s_clr = '0;
    s2h_set = '0;
    s2h_clr = '0;
    if (host_reg_wr && aw_off == H2S_PEND) h2s_set = host_bits;
    if (host_reg_wr && aw_off == S2H_PEND) s2h_clr = host_bits;
    if (pico_reg_wr && pb_off == S2H_PEND) s2h_set = pico_bits;
    if (pico_reg_wr && pb_off == H2S_PEND) h2s_clr = pico_bits;
  end

  // Set is applied after clear so a simultaneous ring is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      h2s_pend              <= '0;
      s2h_pend              <= '0;
      h2s_en                <= '0;
      s2h_en                <= '0;
      interrupt_to_softcore <= 1'b0;
      interrupt_to_linux    <= 1'b0;
    end else begin
      h2s_pend <= (h2s_pend & ~h2s_clr) | h2s_set;
      s2h_pend <= (s2h_pend & ~s2h_clr) | s2h_set;
      if (pico_reg_wr && pb_off == H2S_EN) h2s_en <= (h2s_en & ~pico_lanes) | pico_bits;
      if (host_reg_wr && aw_off == S2H_EN) s2h_en <= (s2h_en & ~host_lanes) | host_bits;
      interrupt_to_softcore <= |(h2s_pend & h2s_en);
      interrupt_to_linux    <= |(s2h_pend & s2h_en);
    end
  end

  assign bus.S_AXI_AWREADY = awready_q;
  assign bus.S_AXI_WREADY  = awready_q;
  assign bus.S_AXI_BVALID  = bvalid_q;
  assign bus.S_AXI_BRESP   = bresp_q;
  assign bus.S_AXI_ARREADY = arready_q;
  assign bus.S_AXI_RVALID  = rvalid_q;
  assign bus.S_AXI_RDATA   = rd_ram_q ? ram_q_a : rd_reg_q;
  assign bus.S_AXI_RRESP   = rresp_q;
  assign bus.mem_ready     = mem_ready_q;
  assign bus.mem_rdata     = mem_ready_q ? (pb_ram_q ? ram_q_b : pb_reg_q) : '0;

  logic unused_inputs;
  assign unused_inputs = ^{bus.S_AXI_AWPROT, bus.S_AXI_ARPROT, bus.mem_instr,
                           bus.S_AXI_AWADDR[1:0], bus.S_AXI_ARADDR[1:0], bus.mem_addr[1:0]};

endmodule

// File: tb/tb_fismos_mailbox_dp.sv
// Directed bench for fismos_mailbox_dp: RAM sharing, doorbells, collisions,
// error responses, read stall and reset mid-transaction.
module tb_fismos_mailbox_dp;

  localparam int unsigned AW = 13;

  logic clk = 1'b0;
  logic reset;
  logic irq_s, irq_l;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  fismos_mailbox_if #(.ADDR_WIDTH(AW)) bus();

  fismos_mailbox_dp #(
    .ADDR_WIDTH   (AW),
    .MEM_WORDS    (1024),
    .NUM_CHANNELS (4)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .interrupt_to_softcore (irq_s),
    .interrupt_to_linux    (irq_l),
    .bus                   (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_awready();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.S_AXI_AWREADY) begin
        seen = 1'b1;
        break;
      end
    end
    check("aw_handshake", 32'(seen), 32'd1);
    check("wready_with_awready", 32'(bus.S_AXI_WREADY), 32'd1);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit release_b, output logic [1:0] resp);
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    wait_awready();
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check("bvalid_rise", 32'(bus.S_AXI_BVALID), 32'd1);
    resp = bus.S_AXI_BRESP;
    if (release_b) begin
      bus.S_AXI_BREADY = 1'b1;
      tick();
      bus.S_AXI_BREADY = 1'b0;
      check("bvalid_fall", 32'(bus.S_AXI_BVALID), 32'd0);
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit seen;
    seen = 1'b0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.S_AXI_ARREADY) begin
        seen = 1'b1;
        break;
      end
    end
    check("ar_handshake", 32'(seen), 32'd1);
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    check("rvalid_rise", 32'(bus.S_AXI_RVALID), 32'd1);
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    check("rvalid_fall", 32'(bus.S_AXI_RVALID), 32'd0);
  endtask

  task automatic pico(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rdata);
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    bus.mem_valid = 1'b1;
    tick();
    check("mem_ready_pulse", 32'(bus.mem_ready), 32'd1);
    rdata = bus.mem_rdata;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    tick();
    check("mem_ready_drop", 32'(bus.mem_ready), 32'd0);
  endtask

  // Host and softcore writes committed on the same clock edge.
  task automatic collide(input logic [AW-1:0] haddr, input logic [31:0] hdata, input logic [3:0] hstrb,
                         input logic [31:0] paddr, input logic [31:0] pdata, input logic [3:0] pstrb);
    bus.S_AXI_AWADDR  = haddr;
    bus.S_AXI_WDATA   = hdata;
    bus.S_AXI_WSTRB   = hstrb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    wait_awready();
    bus.mem_addr  = paddr;
    bus.mem_wdata = pdata;
    bus.mem_wstrb = pstrb;
    bus.mem_valid = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.mem_valid     = 1'b0;
    bus.mem_wstrb     = 4'h0;
    check("collide_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    check("collide_bresp", 32'(bus.S_AXI_BRESP), 32'd0);
    check("collide_mem_ready", 32'(bus.mem_ready), 32'd1);
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  resp;

  initial begin
    reset = 1'b1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0;
    bus.S_AXI_WVALID  = 1'b0; bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0;
    bus.S_AXI_RREADY  = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = '0;
    bus.mem_wdata = '0;   bus.mem_wstrb = '0;
    repeat (3) tick();

    check("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("rst_wready",  32'(bus.S_AXI_WREADY),  32'd0);
    check("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    check("rst_rdata",   bus.S_AXI_RDATA,        32'd0);
    check("rst_mem_ready", 32'(bus.mem_ready),   32'd0);
    check("rst_mem_rdata", bus.mem_rdata,        32'd0);
    check("rst_irq_s", 32'(irq_s), 32'd0);
    check("rst_irq_l", 32'(irq_l), 32'd0);
    reset = 1'b0;
    tick();

    // Host writes RAM, softcore reads it back
    axi_write(13'h010, 32'hDEADBEEF, 4'hF, 1'b1, resp);
    check("ram_wr_bresp", 32'(resp), 32'd0);
    pico(32'h010, 32'h0, 4'h0, rd);
    check("pico_rd_0x010", rd, 32'hDEADBEEF);

    // Host-to-softcore doorbell
    pico(32'h1008, 32'h1, 4'hF, rd);
    axi_write(13'h1000, 32'h1, 4'hF, 1'b1, resp);
    check("h2s_pend_bresp", 32'(resp), 32'd0);
    check("irq_s_set", 32'(irq_s), 32'd1);
    pico(32'h1000, 32'h0, 4'h0, rd);
    check("pico_rd_h2s_pend", rd, 32'h1);
    pico(32'h1000, 32'h1, 4'hF, rd);
    check("irq_s_clear", 32'(irq_s), 32'd0);

    // Same-word RAM collision: host lanes 0..1 win
    collide(13'h014, 32'h11111111, 4'h3, 32'h014, 32'h22222222, 4'hF);
    pico(32'h014, 32'h0, 4'h0, rd);
    check("collide_word5_pico", rd, 32'h22221111);
    axi_read(13'h014, rd, resp);
    check("collide_word5_host", rd, 32'h22221111);

    // Same-bit set/clear on S2H_PEND: set wins
    axi_write(13'h100C, 32'h4, 4'hF, 1'b1, resp);
    check("s2h_en_bresp", 32'(resp), 32'd0);
    collide(13'h1004, 32'h4, 4'hF, 32'h1004, 32'h4, 4'hF);
    check("irq_l_set", 32'(irq_l), 32'd1);
    axi_read(13'h1004, rd, resp);
    check("s2h_pend_kept", rd, 32'h4);
    pico(32'h100C, 32'h0, 4'h0, rd);
    check("pico_rd_s2h_en", rd, 32'h4);

    // Error responses
    axi_read(13'h1040, rd, resp);
    check("oor_rdata", rd, 32'h0);
    check("oor_rresp", 32'(resp), 32'd2);
    axi_write(13'h1008, 32'hF, 4'hF, 1'b1, resp);
    check("h2s_en_host_bresp", 32'(resp), 32'd2);
    pico(32'h1008, 32'h0, 4'h0, rd);
    check("h2s_en_unchanged", rd, 32'h1);

    // Register lane strobes and channel-width masking
    pico(32'h1008, 32'hFF, 4'h2, rd);
    pico(32'h1008, 32'h0, 4'h0, rd);
    check("h2s_en_lane1_only", rd, 32'h1);
    pico(32'h1008, 32'hFF, 4'h1, rd);
    pico(32'h1008, 32'h0, 4'h0, rd);
    check("h2s_en_masked", rd, 32'hF);

    // Softcore out-of-range accesses
    pico(32'h1010, 32'h0, 4'h0, rd);
    check("pico_oor_rd", rd, 32'h0);
    pico(32'h80000010, 32'h12345678, 4'hF, rd);
    pico(32'h80000010, 32'h0, 4'h0, rd);
    check("pico_hi_addr_rd", rd, 32'h0);
    pico(32'h010, 32'h0, 4'h0, rd);
    check("pico_hi_addr_wr_ignored", rd, 32'hDEADBEEF);

    // Read data held while RREADY is low
    bus.S_AXI_ARADDR  = 13'h010;
    bus.S_AXI_ARVALID = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (bus.S_AXI_ARREADY) begin
          seen = 1'b1;
          break;
        end
      end
      check("stall_ar_handshake", 32'(seen), 32'd1);
    end
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
      check("stall_rdata", bus.S_AXI_RDATA, 32'hDEADBEEF);
      tick();
    end
    check("stall_rvalid_end", 32'(bus.S_AXI_RVALID), 32'd1);
    check("stall_rdata_end", bus.S_AXI_RDATA, 32'hDEADBEEF);
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    check("stall_rvalid_fall", 32'(bus.S_AXI_RVALID), 32'd0);

    // Reset while a write response is pending
    axi_write(13'h1000, 32'h1, 4'hF, 1'b0, resp);
    tick();
    check("pre_rst_irq_s", 32'(irq_s), 32'd1);
    check("pre_rst_irq_l", 32'(irq_l), 32'd1);
    check("pre_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_drop_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    check("rst_drop_irq_s", 32'(irq_s), 32'd0);
    check("rst_drop_irq_l", 32'(irq_l), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    pico(32'h1000, 32'h0, 4'h0, rd);
    check("post_rst_h2s_pend", rd, 32'h0);
    pico(32'h1008, 32'h0, 4'h0, rd);
    check("post_rst_h2s_en", rd, 32'h0);
    axi_read(13'h1004, rd, resp);
    check("post_rst_s2h_pend", rd, 32'h0);
    axi_read(13'h100C, rd, resp);
    check("post_rst_s2h_en", rd, 32'h0);
    pico(32'h010, 32'h0, 4'h0, rd);
    check("post_rst_ram_kept", rd, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
